// File: rtl/shdw_pkg.sv
// Shared types and constants for the shadow-chain dump sequencer.
package shdw_pkg;

  localparam int FSL_W = 32;
  localparam logic [7:0] HDR_TAG = 8'hA5;
  localparam logic [7:0] TRL_TAG = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FREEZE = 3'd1,
    ST_SELECT = 3'd2,
    ST_HDR    = 3'd3,
    ST_SHIFT  = 3'd4,
    ST_FLUSH  = 3'd5,
    ST_TRAIL  = 3'd6,
    ST_RESUME = 3'd7
  } state_t;

endpackage

// File: rtl/shdw_word_packer.sv
// Serial-to-32-bit packer: LSB-first word assembly plus a saturating per-chain bit count.
module shdw_word_packer
  import shdw_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             vld,
  input  logic             clr_word,
  input  logic             clr_cnt,
  output logic [FSL_W-1:0] word,
  output logic [23:0]      cnt,
  output logic             word_full,
  output logic             partial
);

  // idx is kept apart from cnt so packing continues after cnt saturates
  logic [4:0] idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word <= '0;
      idx  <= '0;
      cnt  <= '0;
    end else if (clr_cnt) begin
      word <= '0;
      idx  <= '0;
      cnt  <= '0;
    end else if (clr_word) begin
      word <= '0;
      idx  <= '0;
    end else if (vld) begin
      word[idx] <= bit_in;
      idx       <= idx + 5'd1;
      if (cnt != 24'hFFFFFF) cnt <= cnt + 24'd1;
    end
  end

  // word_full flags the cycle in which the 32nd bit of a word is captured
  assign word_full = vld & (idx == 5'd31);
  assign partial   = (idx != 5'd0);

endmodule

// File: rtl/shdw_dump_sched.sv
// Freezes the core, then streams each requested shadow chain over FSL framed by
// header/trailer control words, in ascending chain order, then unfreezes the core.
module shdw_dump_sched
  import shdw_pkg::*;
#(
  parameter int NUM_CHAINS = 32,
  parameter int FREEZE_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_CHAINS-1:0] chain_mask,
  output logic                  busy,
  output logic                  done,
  output logic                  c_en,
  output logic [NUM_CHAINS-1:0] dump_en,
  input  logic [NUM_CHAINS-1:0] sh_out,
  input  logic [NUM_CHAINS-1:0] sh_out_vld,
  input  logic [NUM_CHAINS-1:0] sh_out_done,
  output logic [FSL_W-1:0]      fsl_m_data,
  output logic                  fsl_m_ctrl,
  output logic                  fsl_m_write,
  input  logic                  fsl_m_full,
  output state_t                dbg_state
);

  localparam int CW = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1;

  state_t                state;
  logic [NUM_CHAINS-1:0] pend;
  logic [CW-1:0]         cur;
  logic [CW-1:0]         low_idx;
  logic [15:0]           fcnt;
  logic                  seen_done;
  logic                  sel_vld, sel_done, wr_ok;
  logic [FSL_W-1:0]      pk_word;
  logic [23:0]           pk_cnt;
  logic                  pk_word_full, pk_partial;

  assign sel_vld  = sh_out_vld[cur];
  assign sel_done = sh_out_done[cur];
  assign wr_ok    = !fsl_m_full;

  always_comb begin
    low_idx = '0;
    for (int i = NUM_CHAINS - 1; i >= 0; i--)
      if (pend[i]) low_idx = CW'(i);
  end

  shdw_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (sh_out[cur]),
    .vld       ((state == ST_SHIFT) & sel_vld),
    .clr_word  ((state == ST_FLUSH) & wr_ok),
    .clr_cnt   ((state == ST_TRAIL) & wr_ok),
    .word      (pk_word),
    .cnt       (pk_cnt),
    .word_full (pk_word_full),
    .partial   (pk_partial)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      pend      <= '0;
      cur       <= '0;
      fcnt      <= '0;
      seen_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          pend  <= chain_mask;
          fcnt  <= '0;
          state <= ST_FREEZE;
        end
        ST_FREEZE: begin
          if (fcnt == 16'(FREEZE_CYC - 1)) state <= ST_SELECT;
          else fcnt <= fcnt + 16'd1;
        end
        ST_SELECT: begin
          if (pend == '0) state <= ST_RESUME;
          else begin
            cur   <= low_idx;
            state <= ST_HDR;
          end
        end
        ST_HDR: if (wr_ok) begin
          seen_done <= 1'b0;
          state     <= ST_SHIFT;
        end
        // a bit arriving with done is captured first; a full word always flushes before the trailer
        ST_SHIFT: begin
          if (pk_word_full) begin
            seen_done <= sel_done;
            state     <= ST_FLUSH;
          end else if (sel_done) begin
            seen_done <= 1'b1;
            state     <= (pk_partial | sel_vld) ? ST_FLUSH : ST_TRAIL;
          end
        end
        ST_FLUSH: if (wr_ok) state <= seen_done ? ST_TRAIL : ST_SHIFT;
        ST_TRAIL: if (wr_ok) begin
          pend[cur] <= 1'b0;
          state     <= ST_SELECT;
        end
        ST_RESUME: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // FSL handshake: fsl_m_write pulses only in HDR/FLUSH/TRAIL while fsl_m_full is low;
  // data and ctrl come from held state, so they stay stable while the FIFO is full.
  always_comb begin
    busy        = (state != ST_IDLE);
    done        = (state == ST_RESUME);
    c_en        = (state == ST_IDLE) || (state == ST_RESUME);
    dump_en     = '0;
    if (state == ST_SHIFT) dump_en[cur] = 1'b1;
    fsl_m_ctrl  = (state == ST_HDR) || (state == ST_TRAIL);
    fsl_m_write = ((state == ST_HDR) || (state == ST_FLUSH) || (state == ST_TRAIL)) && wr_ok;
    case (state)
      ST_HDR:   fsl_m_data = {HDR_TAG, 16'h0, 8'(cur)};
      ST_FLUSH: fsl_m_data = pk_word;
      ST_TRAIL: fsl_m_data = {TRL_TAG, pk_cnt};
      default:  fsl_m_data = '0;
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_shdw_dump_sched.sv
// Randomized bench for shdw_dump_sched: a frame-level model of the dump stream feeds a scoreboard.
module tb_shdw_dump_sched;
  import shdw_pkg::*;

  localparam int NC = 32;
  localparam int FC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NC-1:0] chain_mask;
  logic          busy, done, c_en;
  logic [NC-1:0] dump_en;
  logic [NC-1:0] sh_out, sh_out_vld, sh_out_done;
  logic [31:0]   fsl_m_data;
  logic          fsl_m_ctrl, fsl_m_write, fsl_m_full;
  state_t        dbg_state;

  shdw_dump_sched #(.NUM_CHAINS(NC), .FREEZE_CYC(FC)) dut (
    .clk(clk), .rst(rst), .start(start), .chain_mask(chain_mask),
    .busy(busy), .done(done), .c_en(c_en), .dump_en(dump_en),
    .sh_out(sh_out), .sh_out_vld(sh_out_vld), .sh_out_done(sh_out_done),
    .fsl_m_data(fsl_m_data), .fsl_m_ctrl(fsl_m_ctrl), .fsl_m_write(fsl_m_write),
    .fsl_m_full(fsl_m_full), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [127:0] chain_data [NC];
  int           chain_len  [NC];
  logic [32:0]  exp_q[$];
  int           sel_hist[$];
  int           last_writes;
  int           last_clow;

  task automatic fill_chain(input int i, input int len, input bit ones);
    chain_data[i] = '0;
    chain_len[i]  = len;
    for (int b = 0; b < len; b++) chain_data[i][b] = ones ? 1'b1 : 1'(($urandom_range(0, 1)));
  endtask

  // Expected stream: per requested chain in ascending order, header, packed words, trailer
  task automatic build_expected(input logic [NC-1:0] mask);
    logic [31:0] w;
    int nw;
    exp_q.delete();
    for (int i = 0; i < NC; i++) begin
      if (mask[i]) begin
        exp_q.push_back({1'b1, 8'hA5, 16'h0, 8'(i)});
        nw = (chain_len[i] + 31) / 32;
        for (int k = 0; k < nw; k++) begin
          w = chain_data[i][k*32 +: 32];
          exp_q.push_back({1'b0, w});
        end
        exp_q.push_back({1'b1, 8'h5A, 24'(chain_len[i])});
      end
    end
  endtask

  task automatic run_dump(input logic [NC-1:0] mask, input int full_pct, input bit late_done,
                          input bit stall_flush, input bit poke_start);
    int ptr[NC];
    int cyc, stall, sel, clow, writes;
    bit fin, stalled;
    logic [31:0] held;
    logic [32:0] got, expv;
    build_expected(mask);
    sel_hist.delete();
    for (int i = 0; i < NC; i++) ptr[i] = 0;
    @(negedge clk);
    chain_mask = mask;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    chain_mask = $urandom;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL busy_after_start got=%0b exp=1", busy); else n_pass++;
    cyc = 0; fin = 0; stall = 0; stalled = 0; clow = 0; writes = 0; held = '0;
    while (!fin && cyc < 6000) begin
      start = 1'b0;
      if (poke_start && cyc == 15 && busy) begin
        start      = 1'b1;
        chain_mask = $urandom;
      end
      sel = -1;
      for (int i = 0; i < NC; i++) if (dump_en[i]) sel = i;
      if (sel >= 0 && (sel_hist.size() == 0 || sel_hist[$] != sel)) sel_hist.push_back(sel);
      sh_out      = $urandom;
      sh_out_vld  = $urandom;
      sh_out_done = $urandom;
      if (sel >= 0) begin
        sh_out_vld[sel]  = 1'b0;
        sh_out_done[sel] = 1'b0;
        if (ptr[sel] < chain_len[sel]) begin
          if ($urandom_range(0, 3) != 0) begin
            sh_out_vld[sel] = 1'b1;
            sh_out[sel]     = chain_data[sel][ptr[sel]];
            ptr[sel]++;
            if (ptr[sel] == chain_len[sel] && !late_done) sh_out_done[sel] = 1'b1;
          end
        end else if ($urandom_range(0, 1) == 1) begin
          sh_out_done[sel] = 1'b1;
        end
      end
      if (stall_flush && !stalled && dbg_state == ST_FLUSH) begin
        stall   = 10;
        stalled = 1;
        held    = fsl_m_data;
      end
      fsl_m_full = (stall > 0) ? 1'b1 : ($urandom_range(0, 99) < full_pct);
      #1;
      if (stall > 0) begin
        n_checks++;
        if (dump_en !== '0) $display("FAIL stall_dump_en got=%h exp=0", dump_en); else n_pass++;
        n_checks++;
        if (fsl_m_data !== held) $display("FAIL stall_data got=%h exp=%h", fsl_m_data, held); else n_pass++;
        stall--;
      end
      if (fsl_m_full) begin
        n_checks++;
        if (fsl_m_write !== 1'b0) $display("FAIL write_while_full got=%0b exp=0", fsl_m_write); else n_pass++;
      end
      if (dump_en != '0) begin
        n_checks++;
        if (!$onehot0(dump_en)) $display("FAIL dump_en_onehot got=%h", dump_en); else n_pass++;
      end
      if (fsl_m_write === 1'b1) begin
        writes++;
        got = {fsl_m_ctrl, fsl_m_data};
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL unexpected_write got=%h exp=none", got);
        else begin
          expv = exp_q.pop_front();
          if (got !== expv) $display("FAIL fsl_word got=%h exp=%h", got, expv); else n_pass++;
        end
      end
      if (c_en === 1'b0) clow++;
      if (done === 1'b1) begin
        fin = 1;
        n_checks++;
        if (c_en !== 1'b1) $display("FAIL c_en_at_done got=%0b exp=1", c_en); else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL words_left got=%0d exp=0", exp_q.size()); else n_pass++;
        n_checks++;
        if (clow < FC + 1) $display("FAIL freeze_len got=%0d exp>=%0d", clow, FC + 1); else n_pass++;
      end
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (!fin) $display("FAIL dump_timeout got=%0d cycles exp=done", cyc); else n_pass++;
    sh_out_vld = '0; sh_out_done = '0; fsl_m_full = 1'b0; start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL after_done busy=%0b done=%0b exp=0/0", busy, done);
    else n_pass++;
    last_writes = writes;
    last_clow   = clow;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; chain_mask = '0; sh_out = '0; sh_out_vld = '0;
    sh_out_done = '0; fsl_m_full = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%0b exp=0", done); else n_pass++;
    n_checks++; if (c_en !== 1'b1) $display("FAIL reset_c_en got=%0b exp=1", c_en); else n_pass++;
    n_checks++; if (dump_en !== '0) $display("FAIL reset_dump_en got=%h exp=0", dump_en); else n_pass++;
    n_checks++; if (fsl_m_write !== 1'b0) $display("FAIL reset_write got=%0b exp=0", fsl_m_write); else n_pass++;
    n_checks++; if (fsl_m_ctrl !== 1'b0) $display("FAIL reset_ctrl got=%0b exp=0", fsl_m_ctrl); else n_pass++;
    n_checks++; if (fsl_m_data !== 32'h0) $display("FAIL reset_data got=%h exp=0", fsl_m_data); else n_pass++;
  endtask

  task automatic test_single_chain;
    fill_chain(0, 40, 1'b1);
    run_dump(32'h1, 0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (last_writes != 4) $display("FAIL single_writes got=%0d exp=4", last_writes); else n_pass++;
  endtask

  task automatic test_two_chains;
    fill_chain(1, 45, 1'b0);
    fill_chain(4, 20, 1'b0);
    run_dump(32'h12, 0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (sel_hist.size() != 2 || sel_hist[0] != 1 || sel_hist[1] != 4)
      $display("FAIL chain_order got=%0d entries exp=1 then 4", sel_hist.size());
    else n_pass++;
  endtask

  task automatic test_full_stall;
    fill_chain(2, 50, 1'b0);
    run_dump(32'h4, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_exact_word;
    fill_chain(5, 32, 1'b0);
    run_dump(32'h20, 0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (last_writes != 3) $display("FAIL exact_word_writes got=%0d exp=3", last_writes); else n_pass++;
  endtask

  task automatic test_empty;
    fill_chain(3, 0, 1'b0);
    run_dump(32'h8, 0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (last_writes != 2) $display("FAIL zero_bit_writes got=%0d exp=2", last_writes); else n_pass++;
    run_dump(32'h0, 0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (last_writes != 0) $display("FAIL empty_mask_writes got=%0d exp=0", last_writes); else n_pass++;
    n_checks++;
    if (last_clow != FC + 1) $display("FAIL empty_mask_freeze got=%0d exp=%0d", last_clow, FC + 1); else n_pass++;
  endtask

  task automatic test_random;
    logic [NC-1:0] m;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < NC; i++) fill_chain(i, $urandom_range(0, 100), 1'b0);
      m = $urandom & $urandom & $urandom;
      run_dump(m, 20, 1'(it % 2), 1'b0, 1'b1);
    end
  endtask

  task automatic test_reset_mid;
    int k;
    fill_chain(0, 100, 1'b1);
    @(negedge clk);
    chain_mask = 32'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; sh_out = '1; sh_out_vld = '1; sh_out_done = '0;
    k = 0;
    while (dump_en[0] !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    n_checks++;
    if (dump_en[0] !== 1'b1) $display("FAIL mid_reach_shift got=%h exp=1", dump_en); else n_pass++;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++; if (c_en !== 1'b1) $display("FAIL mid_rst_c_en got=%0b exp=1", c_en); else n_pass++;
    n_checks++; if (dump_en !== '0) $display("FAIL mid_rst_dump_en got=%h exp=0", dump_en); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got=%0b exp=0", busy); else n_pass++;
    sh_out_vld = '0;
    @(negedge clk);
    rst = 1'b1;
    fill_chain(6, 37, 1'b0);
    run_dump(32'h40, 10, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_chain();
    test_two_chains();
    test_full_stall();
    test_exact_word();
    test_empty();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
